alu_seq: RTL
============

# alu_seq

Multi-cycle, parametrised successor to the single-cycle 32-bit ALU in the MIPS datapath. The unit executes the same 4-bit ALUControl operation set over a configurable WIDTH. Cheap operations complete in one registered cycle. Shift, rotate, multiply, count-leading and divide operations iterate one bit per cycle behind a Start/Busy/Done handshake, so the EX stage can stall on Busy instead of building wide combinational logic.

## Interface
- WIDTH, 32, operand/result width; power of two, 8..64.
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field taken from B[SHAMT_W-1:0].
- Clk  in  1  clock; all state updates on rising edge.
- Rst_n  in  1  reset; asynchronous, active-low.
- Start  in  1  request; sampled only when Busy=0.
- ALUControl  in  4  operation code, captured with Start.
- A, B  in  WIDTH  operands, captured with Start.
- Busy  out  1  iteration in progress.
- Done  out  1  one-cycle pulse; results valid from this cycle until the next Done.
- ALUResult  out  WIDTH  primary result.
- ALUResultHi  out  WIDTH  MUL high half / DIVU remainder; 0 for other ops.
- Zero  out  1  ALUResult == 0, registered with ALUResult.
- Overflow  out  1  signed overflow for ADD/SUB; 0 otherwise.

## Operation
- Single-cycle ops:
  - 0 AND, 1 OR, 2 ADD, 3 NOR, 4 XOR, 6 SUB.
  - 7 SLT (signed), 11 SGT (signed A>B), 14 SLTU.
  - 5 SEXT: B=0 sign-extends A[7:0]; B=1 sign-extends A[15:0]; other B pass A.
- Iterative ops and their iteration count n:
  - 10 SLL, 13 ROTR and 15 SRA: one bit per cycle, n = B[SHAMT_W-1:0]. n=0 behaves as single-cycle.
  - 9 MUL: unsigned shift-add, n = WIDTH, full 2*WIDTH product on {ALUResultHi, ALUResult}.
  - 12 CLO/CLZ: scans from MSB for bits equal to B[0]. Stops at the first mismatch or after WIDTH bits. n = max(result,1). Result = count (WIDTH if all match).
  - 8 DIVU: see Configuration.
- FSM states:
  - IDLE: Start with a single-cycle op, or iterative op with n=0, stays in IDLE and pulses Done next cycle. Start with an iterative op and n>0 goes to RUN.
  - RUN: counter loads n and decrements each cycle. On the cycle the counter reaches 1, the FSM returns to IDLE and pulses Done.
- Start while Busy=1 is ignored; operands are not re-captured.
- Operands are latched at Start. Changes to A/B/ALUControl during RUN have no effect.

## Timing
- Reset values: ALUResult=0, ALUResultHi=0, Zero=1, Overflow=0, Busy=0, Done=0, FSM=IDLE.
- Rst_n asserted mid-RUN aborts immediately. No Done is produced and outputs take their reset values.
- Single-cycle latency: Start sampled at edge k, Done=1 and results valid after edge k+1.
- Iterative latency: Busy=1 after edges k+1..k+n. Done=1 and Busy=0 after edge k+n+1.
- Back-to-back: Start in the Done cycle is accepted (Busy=0). Throughput is 1 op/cycle for single-cycle ops.
- Results, Zero and Overflow change only on Done edges or reset.

## Configuration
- ALU_SEQ_DIV_EN defined: opcode 8 is DIVU, restoring, n = WIDTH.
  - Quotient goes to ALUResult, remainder to ALUResultHi.
  - Divide by zero: quotient all-ones, remainder = A, same latency.
- ALU_SEQ_DIV_EN undefined: opcode 8 is single-cycle with result 0 and Zero=1, preserving the existing jump encoding.
  - No divider hardware is present.

## Structure
- Package alu_seq_pkg holds:
  - ALUControl opcode localparams (AND..SRA, DIVU).
  - FSM state enum IDLE/RUN.
  - A function flagging iterative opcodes.
- Sub-module alu_seq_logic holds the purely combinational single-cycle operations, parametrised by WIDTH, and computes Overflow.
- The top level owns the operand registers, counter, FSM and iterative datapath.

## Test plan
- Reset: pulse Rst_n low asynchronously mid-cycle -> ALUResult=0, Zero=1, Busy=0 immediately.
- ADD, WIDTH=32: A=32'h7FFFFFFF, B=1, Start -> after 1 edge Done=1, ALUResult=32'h80000000, Overflow=1, Zero=0.
- SRA: A=32'h80000000, B=4 -> Busy for 4 cycles, Done at edge 5, ALUResult=32'hF8000000. Repeat with B=0 -> Done after 1 edge, result=A.
- MUL: A=32'hFFFFFFFF, B=2 -> Done after 33 edges, ALUResultHi=1, ALUResult=32'hFFFFFFFE. Start pulsed during Busy is ignored.
- CLZ: A=32'h00010000, B=0 -> ALUResult=15 after 16 edges. A=0, B=0 -> ALUResult=32.
- With ALU_SEQ_DIV_EN:
  - A=100, B=7 -> quotient 14, remainder 2 after 33 edges.
  - B=0 -> quotient 32'hFFFFFFFF, remainder 100.
  - Rst_n asserted at cycle 10 -> no Done.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state and helpers for the multi-cycle ALU.
// ALU_SEQ_DIV_EN adds opcode 8 (DIVU) to the iterative set.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SEXT = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_DIVU = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_SLL  = 4'd10;
    localparam logic [3:0] OP_SGT  = 4'd11;
    localparam logic [3:0] OP_CLZ  = 4'd12;
    localparam logic [3:0] OP_ROTR = 4'd13;
    localparam logic [3:0] OP_SLTU = 4'd14;
    localparam logic [3:0] OP_SRA  = 4'd15;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_ROTR) || (op == OP_SRA);
    endfunction

    function automatic logic is_iter(input logic [3:0] op);
        logic r;
        r = is_shift(op) || (op == OP_MUL) || (op == OP_CLZ);
`ifdef ALU_SEQ_DIV_EN
        r = r || (op == OP_DIVU);
`endif
        return r;
    endfunction

endpackage

// File: rtl/alu_seq_logic.sv
// alu_seq_logic: combinational single-cycle operations and overflow.
// Iterative opcodes yield 0 here; the top level handles them.
module alu_seq_logic
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sx8;
    logic [WIDTH-1:0] sx16;
    logic             lt_s;
    logic             gt_s;
    logic             lt_u;

    assign sum  = a + b;
    assign diff = a - b;
    assign sx8  = WIDTH'($signed(a[7:0]));
    assign lt_s = $signed(a) < $signed(b);
    assign gt_s = $signed(a) > $signed(b);
    assign lt_u = a < b;

    generate
        if (WIDTH >= 16) begin : g_sx16
            assign sx16 = WIDTH'($signed(a[15:0]));
        end else begin : g_nosx16
            assign sx16 = a;
        end
    endgenerate

    // Opcode decode for the one-cycle result and signed overflow.
    always_comb begin
        res = '0;
        ovf = 1'b0;
        unique case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_NOR:  res = ~(a | b);
            OP_XOR:  res = a ^ b;
            OP_ADD: begin
                res = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                      (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                      (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT:  res = WIDTH'(lt_s);
            OP_SGT:  res = WIDTH'(gt_s);
            OP_SLTU: res = WIDTH'(lt_u);
            OP_SEXT: begin
                if (b == WIDTH'(0))
                    res = sx8;
                else if (b == WIDTH'(1))
                    res = sx16;
                else
                    res = a;
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU, bit-serial shifts/MUL/CLZ behind Start/Busy/Done.
// Define ALU_SEQ_DIV_EN to build the restoring divider on opcode 8.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] ALUResultHi,
    output logic             Zero,
    output logic             Overflow
);

    localparam int CW = SHAMT_W + 1;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       op;
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
    logic [WIDTH-1:0] hi;
    logic [CW-1:0]    cnt;

    logic [SHAMT_W-1:0] shamt;
    logic               go_run;
    logic [CW-1:0]      n_load;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_ovf;
    logic [WIDTH-1:0]   one_res;

    logic [WIDTH-1:0] nxt_wa;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH:0]   sum;
    logic             match;
    logic             clz_stop;
    logic             last;
    logic [WIDTH-1:0] res_it;
    logic [WIDTH-1:0] hi_it;
`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]   t;
`endif

    alu_seq_logic #(.WIDTH(WIDTH)) u_logic (
        .op  (ALUControl),
        .a   (A),
        .b   (B),
        .res (sc_res),
        .ovf (sc_ovf)
    );

    assign shamt   = B[SHAMT_W-1:0];
    assign go_run  = is_iter(ALUControl) &&
                     !(is_shift(ALUControl) && shamt == '0);
    assign n_load  = is_shift(ALUControl) ? CW'(shamt) : CW'(WIDTH);
    // A zero-length shift/rotate is the operand itself.
    assign one_res = is_iter(ALUControl) ? A : sc_res;
    assign Busy    = (state == RUN);

    // One iteration step of the latched operation.
    always_comb begin
        nxt_wa   = wa;
        nxt_hi   = hi;
        sum      = '0;
        match    = 1'b0;
        clz_stop = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        t        = '0;
`endif
        unique case (op)
            OP_SLL:  nxt_wa = wa << 1;
            OP_SRA:  nxt_wa = {wa[WIDTH-1], wa[WIDTH-1:1]};
            OP_ROTR: nxt_wa = {wa[0], wa[WIDTH-1:1]};
            OP_MUL: begin
                sum    = {1'b0, hi} + (wa[0] ? {1'b0, wb} : '0);
                nxt_hi = sum[WIDTH:1];
                nxt_wa = {sum[0], wa[WIDTH-1:1]};
            end
            OP_CLZ: begin
                match    = (wa[WIDTH-1] == wb[0]);
                nxt_hi   = hi + WIDTH'(match);
                nxt_wa   = wa << 1;
                clz_stop = !match || (wa[WIDTH-2] != wb[0]);
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU: begin
                t = {hi, wa[WIDTH-1]};
                if (t >= {1'b0, wb}) begin
                    nxt_hi = t[WIDTH-1:0] - wb;
                    nxt_wa = {wa[WIDTH-2:0], 1'b1};
                end else begin
                    nxt_hi = t[WIDTH-1:0];
                    nxt_wa = {wa[WIDTH-2:0], 1'b0};
                end
            end
`endif
            default: ;
        endcase
    end

    assign last   = (cnt == CW'(1)) || ((op == OP_CLZ) && clz_stop);
    assign res_it = (op == OP_CLZ) ? nxt_hi : nxt_wa;
    assign hi_it  = ((op == OP_MUL) || (op == OP_DIVU)) ? nxt_hi : '0;

    // FSM state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state: enter RUN for non-trivial iterative ops, leave on last step.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (Start && go_run) state_nxt = RUN;
            RUN:  if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration registers and result/flag update on Done.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            op          <= OP_AND;
            wa          <= '0;
            wb          <= '0;
            hi          <= '0;
            cnt         <= '0;
            Done        <= 1'b0;
            ALUResult   <= '0;
            ALUResultHi <= '0;
            Zero        <= 1'b1;
            Overflow    <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (state == IDLE) begin
                if (Start) begin
                    op  <= ALUControl;
                    wa  <= A;
                    wb  <= B;
                    hi  <= '0;
                    cnt <= n_load;
                    if (!go_run) begin
                        Done        <= 1'b1;
                        ALUResult   <= one_res;
                        ALUResultHi <= '0;
                        Zero        <= (one_res == '0);
                        Overflow    <= sc_ovf;
                    end
                end
            end else begin
                wa  <= nxt_wa;
                hi  <= nxt_hi;
                cnt <= cnt - CW'(1);
                if (last) begin
                    Done        <= 1'b1;
                    ALUResult   <= res_it;
                    ALUResultHi <= hi_it;
                    Zero        <= (res_it == '0);
                    Overflow    <= 1'b0;
                end
            end
        end
    end

endmodule
